// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state encoding and the default datapath width.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5,
    MDU_NOP6  = 3'd6,
    MDU_NOP7  = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PREP  = 2'd1,
    ST_ITER  = 2'd2,
    ST_FIXUP = 2'd3
  } mdu_state_e;

endpackage

// File: rtl/mdu_addsub.sv
// Shared add/sub for the multiply and divide iterations. o_carry is the
// carry out; on a subtract it is 1 when i_a >= i_b (no borrow).
module mdu_addsub #(
  parameter int W = 33
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_sub,
  output logic [W-1:0] o_sum,
  output logic         o_carry
);

  logic [W-1:0] w_b;

  assign w_b = i_sub ? ~i_b : i_b;
  assign {o_carry, o_sum} = {1'b0, i_a} + {1'b0, w_b} + (W+1)'(i_sub);

endmodule

// File: rtl/mdu_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
// Operands are reduced to magnitudes, iterated WIDTH times, then signed in FIXUP.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  mdu_state_e       r_state;
  mdu_op_e          r_op;
  logic [WIDTH:0]   r_acc;    // product high half / partial remainder
  logic [WIDTH-1:0] r_q;      // A, then multiplier / quotient
  logic [WIDTH:0]   r_m;      // B, then multiplicand / divisor
  logic [CW-1:0]    r_cnt;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_is_mul;
  logic             w_is_signed;
  logic             w_div_zero;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_as_a;
  logic [WIDTH:0]   w_as_b;
  logic [WIDTH:0]   w_sum;
  logic             w_carry;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [WIDTH-1:0] w_quot;
  logic [WIDTH-1:0] w_rem;

  assign w_is_mul    = (r_op == MDU_MULT) || (r_op == MDU_MULTU);
  assign w_is_signed = (r_op == MDU_MULT) || (r_op == MDU_DIV);
  assign w_div_zero  = (r_m[WIDTH-1:0] == '0);

  // Magnitude in WIDTH bits: the most negative value maps to +2^(WIDTH-1).
  assign w_mag_a = (w_is_signed && r_q[WIDTH-1]) ? -r_q : r_q;
  assign w_mag_b = (w_is_signed && r_m[WIDTH-1]) ? -r_m[WIDTH-1:0] : r_m[WIDTH-1:0];

  assign w_rem_sh = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_as_a   = w_is_mul ? r_acc : w_rem_sh;
  assign w_as_b   = w_is_mul ? (r_q[0] ? r_m : '0) : r_m;

  mdu_addsub #(.W(WIDTH+1)) u_addsub (
    .i_a     (w_as_a),
    .i_b     (w_as_b),
    .i_sub   (!w_is_mul),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  assign w_prod   = {r_acc[WIDTH-1:0], r_q};
  assign w_prod_s = r_neg_q ? -w_prod : w_prod;
  assign w_quot   = r_neg_q ? -r_q : r_q;
  assign w_rem    = r_neg_r ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];

  // NOTE: every register here is sequential state and uses non-blocking
  // assignment; datapath registers are reset too so an aborted op leaves
  // no residue for the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_op    <= MDU_MULT;
      r_acc   <= '0;
      r_q     <= '0;
      r_m     <= '0;
      r_cnt   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            case (mdu_op_e'(op))
              MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                r_op    <= mdu_op_e'(op);
                r_q     <= A;
                r_m     <= {1'b0, B};
                r_busy  <= 1'b1;
                r_state <= ST_PREP;
              end
              MDU_MTHI: r_hi <= A;
              MDU_MTLO: r_lo <= A;
              default: ;
            endcase
          end
        end

        ST_PREP: begin
          r_neg_q <= w_is_signed && (r_q[WIDTH-1] ^ r_m[WIDTH-1]);
          r_neg_r <= w_is_signed && r_q[WIDTH-1];
          if (!w_is_mul && w_div_zero) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= ST_ITER;
            if (w_is_mul) begin
              r_q <= w_mag_b;
              r_m <= {1'b0, w_mag_a};
            end else begin
              r_q <= w_mag_a;
              r_m <= {1'b0, w_mag_b};
            end
          end
        end

        ST_ITER: begin
          if (w_is_mul) begin
            r_acc <= {1'b0, w_sum[WIDTH:1]};
            r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
          end else begin
            r_acc <= w_carry ? w_sum : w_rem_sh;
            r_q   <= {r_q[WIDTH-2:0], w_carry};
          end
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH-1)) r_state <= ST_FIXUP;
        end

        ST_FIXUP: begin
          if (w_is_mul) begin
            {r_hi, r_lo} <= w_prod_s;
          end else begin
            r_lo <= w_quot;
            r_hi <= w_rem;
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: hand-computed products, quotients, latency,
// divide-by-zero, ignored starts while busy and mid-operation reset.
module tb_mdu_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  mdu_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one start for exactly one rising edge; returns at the next falling edge.
  task automatic issue(input logic [2:0] i_op, input logic [31:0] i_a, input logic [31:0] i_b);
    @(negedge clk);
    start = 1'b1;
    op    = i_op;
    A     = i_a;
    B     = i_b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts busy cycles (bounded) and reports done as busy drops.
  task automatic wait_idle(output int cycles, output logic done_at_end);
    cycles = 0;
    while (busy && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
    done_at_end = done;
  endtask

  task automatic run_op(input string name, input logic [2:0] i_op,
                        input logic [31:0] i_a, input logic [31:0] i_b,
                        input int exp_cyc, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int   cyc;
    logic d;
    issue(i_op, i_a, i_b);
    wait_idle(cyc, d);
    n_vec++;
    if (cyc !== exp_cyc) begin
      n_err++;
      $display("FAIL %s busy_cycles got %0d want %0d", name, cyc, exp_cyc);
    end
    n_vec++;
    if (d !== 1'b1) begin
      n_err++;
      $display("FAIL %s done got %b want 1", name, d);
    end
    n_vec++;
    if (hi !== exp_hi) begin
      n_err++;
      $display("FAIL %s hi got %h want %h", name, hi, exp_hi);
    end
    n_vec++;
    if (lo !== exp_lo) begin
      n_err++;
      $display("FAIL %s lo got %h want %h", name, lo, exp_lo);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL %s done_pulse got %b want 0", name, done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    op    = 3'd0;
    A     = '0;
    B     = '0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy, done} !== 2'b00) begin
      n_err++;
      $display("FAIL reset busy_done got %b want 00", {busy, done});
    end
    n_vec++;
    if ({hi, lo} !== 64'd0) begin
      n_err++;
      $display("FAIL reset hilo got %h want 0", {hi, lo});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult();
    run_op("mult_neg3x5", OP_MULT, 32'hFFFF_FFFD, 32'd5, 34, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("mult_neg2xneg3", OP_MULT, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, 32'h0, 32'h6);
    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'hFFFF_FFFE, 32'h0000_0001);
  endtask

  task automatic test_div();
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 34, 32'd2, 32'd14);
    run_op("div_neg7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_7_neg2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 34, 32'd1, 32'hFFFF_FFFD);
    run_op("div_min_neg1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h0, 32'h8000_0000);
  endtask

  task automatic test_div_zero();
    issue(OP_MTHI, 32'h11, 32'h0);
    n_vec++;
    if (hi !== 32'h11 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL mthi_idle hi/busy/done got %h/%b/%b want 00000011/0/0", hi, busy, done);
    end
    issue(OP_MTLO, 32'h22, 32'h0);
    n_vec++;
    if (lo !== 32'h22 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL mtlo_idle lo/busy got %h/%b want 00000022/0", lo, busy);
    end
    run_op("div_by_zero", OP_DIV, 32'd5, 32'd0, 1, 32'h11, 32'h22);
  endtask

  task automatic test_ignore_while_busy();
    int cyc;
    issue(OP_MULT, 32'h1234, 32'h100);
    cyc = 0;
    while (busy && cyc < 200) begin
      if (cyc == 10) begin
        start = 1'b1; op = OP_MTHI; A = 32'hAAAA; B = 32'h0;
      end else if (cyc == 20) begin
        start = 1'b1; op = OP_MULTU; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF;
      end else begin
        start = 1'b0;
      end
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    n_vec++;
    if (cyc !== 34) begin
      n_err++;
      $display("FAIL ignore_busy busy_cycles got %0d want 34", cyc);
    end
    n_vec++;
    if ({hi, lo} !== 64'h0000_0000_0012_3400) begin
      n_err++;
      $display("FAIL ignore_busy product got %h want 0000000000123400", {hi, lo});
    end
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL ignore_busy relaunch busy got %b want 0", busy);
    end
    issue(OP_MTHI, 32'hAAAA, 32'h0);
    n_vec++;
    if (hi !== 32'hAAAA || busy !== 1'b0) begin
      n_err++;
      $display("FAIL mthi_after hi/busy got %h/%b want 0000aaaa/0", hi, busy);
    end
  endtask

  task automatic test_reset_mid_op();
    issue(OP_DIVU, 32'd1000, 32'd3);
    repeat (14) @(negedge clk);
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reset pre busy got %b want 1", busy);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({busy, done} !== 2'b00 || {hi, lo} !== 64'd0) begin
      n_err++;
      $display("FAIL mid_reset busy/done/hi/lo got %b/%b/%h/%h want 0/0/0/0", busy, done, hi, lo);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op("divu_after_reset", OP_DIVU, 32'd1000, 32'd3, 34, 32'd1, 32'd333);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_ignore_while_busy();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
